// File: rtl/gesture_cmd_filter.sv
// Debounce and auto-repeat filter for per-frame gesture directions.
// Turns a one-direction-per-frame stream into single-cycle command pulses.
module gesture_cmd_filter #(
    parameter int STABLE_FRAMES  = 4,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 10,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic [1:0] dir_in,
    input  logic       valid_in,
    output logic [1:0] cmd_out,
    output logic       cmd_valid_out,
    output logic       repeat_out,
    output logic [1:0] state_out
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_PRE = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [7:0] STABLE_C = 8'(STABLE_FRAMES);
    localparam logic [7:0] DELAY_C  = 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE_C   = 8'(REPEAT_RATE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMING = 2'b01,
        ST_HOLD   = 2'b10,
        ST_REPEAT = 2'b11
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [1:0]      cand_r;
    logic [1:0]      cand_nxt_s;
    logic [7:0]      frame_cnt_r;
    logic [7:0]      frame_nxt_s;
    logic [7:0]      frame_inc_s;
    logic [WD_W-1:0] wd_cnt_r;
    logic [WD_W-1:0] wd_nxt_s;
    logic            timeout_s;
    logic            start_s;
    logic            fire_s;
    logic [1:0]      cmd_r;
    logic [1:0]      cmd_nxt_s;
    logic            cmd_valid_r;
    logic            repeat_r;
    logic [1:0]      state_out_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'd255) begin
            return 8'd255;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Next-state, counter and pulse decision for the filter
    always_comb begin
        state_nxt_s = state_r;
        cand_nxt_s  = cand_r;
        frame_nxt_s = frame_cnt_r;
        frame_inc_s = sat_inc(frame_cnt_r);
        start_s     = 1'b0;
        fire_s      = 1'b0;
        timeout_s   = (wd_cnt_r >= WD_PRE) && (state_r != ST_IDLE);

        if (valid_in) begin
            wd_nxt_s = {WD_W{1'b0}};
        end else if (wd_cnt_r >= WD_MAX) begin
            wd_nxt_s = WD_MAX;
        end else begin
            wd_nxt_s = wd_cnt_r + WD_W'(1);
        end

        if (!enable_in) begin
            state_nxt_s = ST_IDLE;
            frame_nxt_s = 8'd0;
        end else if (valid_in) begin
            case (state_r)
                ST_IDLE: begin
                    start_s = 1'b1;
                end
                ST_ARMING: begin
                    if (dir_in != cand_r) begin
                        start_s = 1'b1;
                    end else if (frame_inc_s == STABLE_C) begin
                        fire_s      = 1'b1;
                        state_nxt_s = ST_HOLD;
                        frame_nxt_s = 8'd0;
                    end else begin
                        frame_nxt_s = frame_inc_s;
                    end
                end
                ST_HOLD: begin
                    if (dir_in != cand_r) begin
                        start_s = 1'b1;
                    end else if (frame_inc_s == DELAY_C) begin
                        fire_s      = 1'b1;
                        state_nxt_s = ST_REPEAT;
                        frame_nxt_s = 8'd0;
                    end else begin
                        frame_nxt_s = frame_inc_s;
                    end
                end
                ST_REPEAT: begin
                    if (dir_in != cand_r) begin
                        start_s = 1'b1;
                    end else if (frame_inc_s == RATE_C) begin
                        fire_s      = 1'b1;
                        frame_nxt_s = 8'd0;
                    end else begin
                        frame_nxt_s = frame_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    frame_nxt_s = 8'd0;
                end
            endcase

            // A new candidate either fires at once (single-frame debounce) or starts arming
            if (start_s) begin
                cand_nxt_s = dir_in;
                if (STABLE_C == 8'd1) begin
                    fire_s      = 1'b1;
                    state_nxt_s = ST_HOLD;
                    frame_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = ST_ARMING;
                    frame_nxt_s = 8'd1;
                end
            end else begin
                cand_nxt_s = cand_r;
            end
        end else if (timeout_s) begin
            state_nxt_s = ST_IDLE;
            frame_nxt_s = 8'd0;
        end else begin
            state_nxt_s = state_r;
        end

        if (fire_s) begin
            cmd_nxt_s = cand_nxt_s;
        end else begin
            cmd_nxt_s = cmd_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r     <= ST_IDLE;
            cand_r      <= 2'b00;
            frame_cnt_r <= 8'd0;
            wd_cnt_r    <= {WD_W{1'b0}};
            cmd_r       <= 2'b00;
            cmd_valid_r <= 1'b0;
            repeat_r    <= 1'b0;
            state_out_r <= 2'b00;
        end else begin
            state_r     <= state_nxt_s;
            cand_r      <= cand_nxt_s;
            frame_cnt_r <= frame_nxt_s;
            wd_cnt_r    <= wd_nxt_s;
            cmd_r       <= cmd_nxt_s;
            cmd_valid_r <= fire_s;
            repeat_r    <= (state_nxt_s == ST_REPEAT);
            state_out_r <= state_nxt_s;
        end
    end

    assign cmd_out       = cmd_r;
    assign cmd_valid_out = cmd_valid_r;
    assign repeat_out    = repeat_r;
    assign state_out     = state_out_r;

endmodule

// File: tb/tb_gesture_cmd_filter.sv
// Directed bench for gesture_cmd_filter with a pulse scoreboard.
module tb_gesture_cmd_filter;

    localparam int T  = 1000;
    localparam int SP = 100;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       enable_in = 1'b1;
    logic [1:0] dir_in = 2'b00;
    logic       valid_in = 1'b0;
    logic [1:0] cmd_out;
    logic       cmd_valid_out;
    logic       repeat_out;
    logic [1:0] state_out;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_pulses = 0;
    int         pulse_base = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;
    logic       p;
    logic [1:0] st;

    gesture_cmd_filter #(
        .STABLE_FRAMES(4), .REPEAT_DELAY(30), .REPEAT_RATE(10), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .dir_in(dir_in),
        .valid_in(valid_in), .cmd_out(cmd_out), .cmd_valid_out(cmd_valid_out),
        .repeat_out(repeat_out), .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every pulse must match the oldest expected command
    always @(negedge clk_in) begin
        if (cmd_valid_out === 1'b1) begin
            n_pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_pulse observed cmd=%b expected=no pulse", cmd_out);
            end else begin
                mon_exp = exp_q.pop_front();
                assert (cmd_out === mon_exp) else begin
                    n_fail++;
                    $error("FAIL pulse_cmd observed=%b expected=%b", cmd_out, mon_exp);
                end
            end
        end
    end

    task automatic strobe(input logic [1:0] d, input logic exp_pulse, input string tag);
        @(negedge clk_in);
        dir_in   = d;
        valid_in = 1'b1;
        if (exp_pulse) exp_q.push_back(d);
        @(negedge clk_in);
        valid_in = 1'b0;
        check({tag, "_pulse"}, {1'b0, cmd_valid_out}, {1'b0, exp_pulse});
    endtask

    task automatic gap();
        repeat (SP - 2) @(negedge clk_in);
    endtask

    task automatic strobe_gap(input logic [1:0] d, input logic exp_pulse, input string tag);
        strobe(d, exp_pulse, tag);
        gap();
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        check("rst_state", state_out, 2'b00);
        check("rst_cmd", cmd_out, 2'b00);
        check("rst_valid", {1'b0, cmd_valid_out}, 2'b00);
        check("rst_repeat", {1'b0, repeat_out}, 2'b00);
        rst_in = 1'b0;
        repeat (5) @(negedge clk_in);

        // basic arming to first command
        for (int i = 1; i <= 4; i++) strobe_gap(2'b10, i == 4, "t1");
        check("t1_cmd", cmd_out, 2'b10);
        check("t1_state", state_out, 2'b10);

        // candidate changes restart the count
        for (int i = 1; i <= 3; i++) strobe_gap(2'b00, 1'b0, "t2_up");
        check("t2_arming", state_out, 2'b01);
        for (int i = 1; i <= 4; i++) strobe_gap(2'b01, i == 4, "t2_down");
        check("t2_cmd", cmd_out, 2'b01);

        // auto-repeat
        pulse_base = n_pulses;
        for (int i = 1; i <= 59; i++) begin
            p  = (i == 4) || (i == 34) || (i == 44) || (i == 54);
            st = (i < 4) ? 2'b01 : ((i < 34) ? 2'b10 : 2'b11);
            strobe(2'b11, p, "t3");
            check("t3_state", state_out, st);
            check("t3_repeat", {1'b0, repeat_out}, {1'b0, (i >= 34)});
            gap();
        end
        check_int("t3_pulse_count", n_pulses - pulse_base, 4);
        check("t3_cmd", cmd_out, 2'b11);

        // watchdog timeout from HOLD
        for (int i = 1; i <= 3; i++) strobe_gap(2'b10, 1'b0, "t4_arm");
        strobe(2'b10, 1'b1, "t4_fire");
        repeat (T - 2) @(negedge clk_in);
        check("t4_before_timeout", state_out, 2'b10);
        @(negedge clk_in);
        check("t4_timeout", state_out, 2'b00);
        gap();
        for (int i = 1; i <= 3; i++) strobe_gap(2'b10, 1'b0, "t4_after");
        check("t4_after_state", state_out, 2'b01);

        // async reset in REPEAT with frame_cnt=9
        for (int i = 1; i <= 50; i++) strobe_gap(2'b10, (i == 1) || (i == 31) || (i == 41), "t5");
        check("t5_in_repeat", state_out, 2'b11);
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        check("t5_rst_cmd", cmd_out, 2'b00);
        check("t5_rst_valid", {1'b0, cmd_valid_out}, 2'b00);
        check("t5_rst_repeat", {1'b0, repeat_out}, 2'b00);
        check("t5_rst_state", state_out, 2'b00);
        @(negedge clk_in);
        rst_in = 1'b0;
        gap();
        strobe_gap(2'b10, 1'b0, "t5_post");
        check("t5_post_state", state_out, 2'b01);

        // enable drop during arming
        for (int i = 1; i <= 3; i++) strobe_gap(2'b00, 1'b0, "t6_arm");
        check("t6_arming", state_out, 2'b01);
        @(negedge clk_in);
        enable_in = 1'b0;
        @(negedge clk_in);
        check("t6_disabled_state", state_out, 2'b00);
        for (int i = 1; i <= 2; i++) strobe_gap(2'b00, 1'b0, "t6_dis");
        check("t6_dis_state", state_out, 2'b00);
        enable_in = 1'b1;
        for (int i = 1; i <= 4; i++) strobe_gap(2'b00, i == 4, "t6_en");
        check("t6_state", state_out, 2'b10);

        repeat (5) @(negedge clk_in);
        check_int("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gesture_cmd_filter.md
Name: gesture_cmd_filter

Overview:
- Sits directly downstream of the per-frame key_input classifier and upstream of game_state, all in the 65 MHz pixel domain.
- Turns the classifier's one-direction-per-frame stream into clean single-cycle command pulses.
- Requires a direction to be stable for several frames before issuing a command.
- Issues a first command, then auto-repeats after a hold delay while the direction persists.
- Drops to idle when frames stop arriving or the filter is disabled.

Parameters:
- STABLE_FRAMES, 4, consecutive identical frames needed before the first command (legal range 1..255).
- REPEAT_DELAY, 30, frames of continued hold after the first command before the first repeat (1..255).
- REPEAT_RATE, 10, frames between subsequent repeats (1..255).
- TIMEOUT_CYCLES, 2_000_000, clock cycles without valid_in before returning to IDLE (about 2 frames at 65 MHz).

Ports:
- clk_in  input  1  65 MHz pixel clock.
- rst_in  input  1  asynchronous, active-high reset.
- enable_in  input  1  filter enable; when low, forces IDLE and suppresses pulses.
- dir_in  input  2  direction code from key_input (00 up, 01 down, 10 right, 11 left).
- valid_in  input  1  one-cycle strobe, at most once per frame; dir_in is sampled when it is high.
- cmd_out  output  2  direction of the most recent command; held between pulses.
- cmd_valid_out  output  1  one-cycle command pulse.
- repeat_out  output  1  high while in REPEAT state.
- state_out  output  2  current state (00 IDLE, 01 ARMING, 10 HOLD, 11 REPEAT), for debug.

Behaviour:
- Reset (asynchronous assert, any cycle): state IDLE, cand=0, frame_cnt=0, wd_cnt=0, cmd_out=00, cmd_valid_out=0, repeat_out=0, state_out=00.
  - No pulse is emitted for a reset that arrives mid-count.
- All outputs are registered. cmd_valid_out rises exactly 1 cycle after the valid_in edge that completes a condition and is high for 1 cycle only. cmd_out updates in that same cycle.
- Frame counter frame_cnt is 8 bits and saturates at 255. It never wraps.
- State transitions are evaluated only on cycles where valid_in=1 and enable_in=1.
- IDLE: on valid_in, cand<=dir_in, frame_cnt<=1, go to ARMING.
  - If STABLE_FRAMES==1, fire immediately instead: pulse, go to HOLD, frame_cnt<=0.
- ARMING:
  - dir_in!=cand: cand<=dir_in, frame_cnt<=1, stay in ARMING.
  - dir_in==cand: frame_cnt++. When the incremented value equals STABLE_FRAMES: pulse with cmd_out=cand, go to HOLD, frame_cnt<=0.
- HOLD:
  - dir_in!=cand: go to ARMING with the new cand, frame_cnt<=1. No pulse.
  - dir_in==cand: frame_cnt++. At REPEAT_DELAY: pulse, go to REPEAT, frame_cnt<=0.
- REPEAT:
  - dir_in!=cand: go to ARMING as above.
  - dir_in==cand: frame_cnt++. At REPEAT_RATE: pulse, frame_cnt<=0, stay in REPEAT.
- Watchdog:
  - wd_cnt increments every cycle and is cleared on any valid_in.
  - When it reaches TIMEOUT_CYCLES-1 (any state other than IDLE): go to IDLE, frame_cnt<=0. wd_cnt saturates there.
  - valid_in on the same cycle as timeout: valid_in wins. It is processed normally and wd_cnt is cleared.
- enable_in=0: state<=IDLE, frame_cnt<=0, cmd_valid_out=0 next cycle. cmd_out keeps its last value. valid_in is ignored.
- valid_in held high for consecutive cycles: each high cycle counts as a separate frame. The bench never does this except in the dedicated stress case.
- repeat_out is the registered decode of state==REPEAT.

Test Plan:
- Reset, then 4 valid_in strobes with dir_in=10, spaced 100 cycles -> cmd_valid_out pulses once, 1 cycle after the 4th strobe; cmd_out=10; state_out=10.
- Strobes with dir_in 00,00,00,01,01,01,01 -> no pulse during the 00s; one pulse after the 4th 01 with cmd_out=01.
- 4+30+25 strobes of dir_in=11 -> pulses after frames 4, 34, 44, 54; repeat_out rises with the 34 pulse; exactly 4 pulses total.
- Reach HOLD, then stop strobes for TIMEOUT_CYCLES -> state_out=00 at cycle TIMEOUT_CYCLES-1 after the last strobe; 3 more strobes then produce no pulse.
- Assert rst_in asynchronously (mid-cycle) while in REPEAT with frame_cnt=9 -> all outputs at reset values immediately; no pulse.
- Drop enable_in during ARMING at frame_cnt=3 and strobe twice -> no pulse. Re-enable and give 4 matching strobes -> one pulse after the 4th.
